// File: rtl/uart_receiver_word.sv
// 8N1 UART receiver that assembles four consecutive valid bytes into a
// little-endian 32-bit word and pulses a ready flag when the word is complete.
module uart_receiver_word #(
    parameter int CLKS_PER_BIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxD,
    output logic [31:0] RxD_word_data,
    output logic        RxD_word_data_ready
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic          rx_meta_r;
    logic          rxs_r;
    state_t        state_r,    state_s;
    logic [CW-1:0] cnt_r,      cnt_s;
    logic [2:0]    idx_r,      idx_s;
    logic [7:0]    shift_r,    shift_s;
    logic [1:0]    byte_cnt_r, byte_cnt_s;
    logic [23:0]   asm_r,      asm_s;
    logic [31:0]   word_s;
    logic          ready_s;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= RxD;
            rxs_r     <= rx_meta_r;
        end
    end

    // Frame decoding and word assembly next-state logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        shift_s    = shift_r;
        byte_cnt_s = byte_cnt_r;
        asm_s      = asm_r;
        word_s     = RxD_word_data;
        ready_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rxs_r) begin
                    cnt_s   = CNT_ZERO;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    idx_s = 3'd0;
                    if (!rxs_r) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s          = CNT_ZERO;
                    shift_s[idx_r] = rxs_r;
                    idx_s          = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                if (cnt_r == BIT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                    if (rxs_r) begin
                        if (byte_cnt_r == 2'd3) begin
                            word_s     = {shift_r, asm_r};
                            ready_s    = 1'b1;
                            byte_cnt_s = 2'd0;
                        end else begin
                            asm_s[{byte_cnt_r, 3'b000} +: 8] = shift_r;
                            byte_cnt_s = byte_cnt_r + 2'd1;
                        end
                    end else begin
                        byte_cnt_s = byte_cnt_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r             <= IDLE;
            cnt_r               <= CNT_ZERO;
            idx_r               <= 3'd0;
            shift_r             <= 8'h00;
            byte_cnt_r          <= 2'd0;
            asm_r               <= 24'h000000;
            RxD_word_data       <= 32'h0000_0000;
            RxD_word_data_ready <= 1'b0;
        end else begin
            state_r             <= state_s;
            cnt_r               <= cnt_s;
            idx_r               <= idx_s;
            shift_r             <= shift_s;
            byte_cnt_r          <= byte_cnt_s;
            asm_r               <= asm_s;
            RxD_word_data       <= word_s;
            RxD_word_data_ready <= ready_s;
        end
    end

endmodule

// File: tb/tb_uart_receiver_word.sv
// Self-checking bench: serial frames are driven on RxD while a byte-queue
// model predicts the completed little-endian words and their pulse timing.
module tb_uart_receiver_word;

    localparam int CPB = 64;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic        clk;
    logic        rst;
    logic        RxD;
    logic [31:0] RxD_word_data;
    logic        RxD_word_data_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hold_viol = 0;
    int wide_cnt = 0;
    int last_start = 0;
    int word_start = 0;

    logic [7:0]  model_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_cyc[$];

    logic        ready_prev = 1'b0;
    logic        rst_prev = 1'b1;
    logic [31:0] data_prev = 32'h0;

    uart_receiver_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk                (clk),
        .rst                (rst),
        .RxD                (RxD),
        .RxD_word_data      (RxD_word_data),
        .RxD_word_data_ready(RxD_word_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every ready pulse and flags output changes outside a pulse.
    always @(negedge clk) begin
        if (RxD_word_data_ready === 1'b1) begin
            got_q.push_back(RxD_word_data);
            got_cyc.push_back(cyc);
            if (ready_prev === 1'b1) wide_cnt <= wide_cnt + 1;
        end
        if (!rst && !rst_prev && RxD_word_data_ready !== 1'b1 && RxD_word_data !== data_prev)
            hold_viol <= hold_viol + 1;
        ready_prev <= RxD_word_data_ready;
        rst_prev   <= rst;
        data_prev  <= RxD_word_data;
    end

    task automatic line(input logic v, input int n);
        RxD = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        last_start = cyc;
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(good ? 1'b1 : 1'b0, CPB);
        RxD = 1'b1;
        if (good) begin
            model_q.push_back(b);
            if (model_q.size() == 4) begin
                exp_q.push_back({model_q[3], model_q[2], model_q[1], model_q[0]});
                word_start = last_start;
                model_q.delete();
            end
        end else begin
            line(1'b1, CPB);
        end
    endtask

    task automatic drain();
        line(1'b1, 2 * CPB);
    endtask

    task automatic clear_queues();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RxD = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (RxD_word_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=%h", RxD_word_data, 32'h0);
        end
        checks++;
        if (RxD_word_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", RxD_word_data_ready);
        end
        rst = 1'b0;
        model_q.delete();
        line(1'b1, 8);
        clear_queues();
    endtask

    task automatic test_known_word();
        int lat;
        clear_queues();
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL known_pulses got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'h12345678) begin
                errors++;
                $display("FAIL known_word got=%h exp=%h", got_q[0], 32'h12345678);
            end
            lat = got_cyc[0] - word_start;
            checks++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
                errors++;
                $display("FAIL known_latency got=%0d exp=%0d", lat, LAT);
            end
        end
    endtask

    task automatic test_zeros_ones();
        clear_queues();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b1);
        checks++;
        if (RxD_word_data !== 32'h0) begin
            errors++;
            $display("FAIL zeros_hold got=%h exp=%h", RxD_word_data, 32'h0);
        end
        send_byte(8'hFF, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL zeros_ones_pulses got=%0d exp=2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'h0000_0000) begin
                errors++;
                $display("FAIL zeros_word got=%h exp=%h", got_q[0], 32'h0);
            end
            checks++;
            if (got_q[1] !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL ones_word got=%h exp=%h", got_q[1], 32'hFFFF_FFFF);
            end
        end
    endtask

    task automatic test_glitch();
        clear_queues();
        line(1'b0, 10);
        line(1'b1, 2 * CPB);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        drain();
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() != 1) begin
            errors++;
            $display("FAIL glitch_pulses got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL glitch_word got=%h exp=%h", got_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_framing_error();
        clear_queues();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), i != 2);
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL framing_pulses got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL framing_word got=%h exp=%h", got_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] part;
        clear_queues();
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        part = 8'($urandom_range(0, 255));
        line(1'b0, CPB);
        for (int i = 0; i < 3; i++) line(part[i], CPB);
        rst = 1'b1;
        line(1'b1, 3);
        rst = 1'b0;
        model_q.delete();
        line(1'b1, CPB);
        checks++;
        if (RxD_word_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_data got=%h exp=%h", RxD_word_data, 32'h0);
        end
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_early_pulse got=%0d exp=0", got_q.size());
        end
        send_byte(8'hDD, 1'b1);
        drain();
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL rst_mid_pulses got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'hDDCCBBAA) begin
                errors++;
                $display("FAIL rst_mid_word got=%h exp=%h", got_q[0], 32'hDDCCBBAA);
            end
        end
    endtask

    task automatic test_random();
        int guard;
        clear_queues();
        guard = 0;
        while (exp_q.size() < 3 && guard < 40) begin
            send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0);
            if ($urandom_range(0, 1) == 1) line(1'b1, $urandom_range(1, CPB));
            guard++;
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_pulses got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_integrity();
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL data_hold got=%0d changes exp=0", hold_viol);
        end
        checks++;
        if (wide_cnt != 0) begin
            errors++;
            $display("FAIL pulse_width got=%0d wide pulses exp=0", wide_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        RxD = 1'b1;
        test_reset();
        test_known_word();
        test_zeros_ones();
        test_glitch();
        test_framing_error();
        test_reset_midword();
        test_random();
        test_integrity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
